mc_controller: RTL
==================

MC_CONTROLLER -- requirements
Module: mc_controller

Interface
REQ-001 SHALL have parameter WAIT_MAX, default 15, which sets the memory-wait timeout in cycles; 0 disables the timeout.
REQ-002 SHALL have parameter ENABLE_EXT, default 1; when 1, bltz, bgtz, xor, srl and srlv decode as legal; when 0 they decode as illegal.
REQ-003 SHALL provide these ports. One clock; reset is asynchronous and active-high.
- clk  in  1  clock
- reset  in  1  async active-high reset
- op  in  6  instruction opcode
- funct  in  6  instruction function field
- comparator_result  in  1  branch condition result from the datapath comparator
- mem_ready  in  1  memory has completed the current access
- mem_req  out  1  memory access request
- iord  out  1  memory address select: 0 = PC, 1 = ALU result
- irwrite  out  1  instruction register write enable
- memwrite  out  1  memory write enable
- regwrite  out  1  register file write enable
- regdst  out  1  destination register select: 1 = rd
- memtoreg  out  1  write-back select: 1 = memory data
- alusrca  out  1  ALU A select: 0 = PC, 1 = rs
- alusrcb  out  2  ALU B select: 00 = rt, 01 = 4, 10 = immediate, 11 = branch offset
- pcsrc  out  2  PC source select: 00 = ALU, 01 = ALUOut, 10 = jump target, 11 = rs
- pcen  out  1  PC write enable
- branch  out  1  branch state active
- i_type  out  1  zero-extend immediate (andi, ori)
- if_srl  out  1  op=0 and funct=000010
- jump_register  out  1  funct=001000
- alucontrol  out  4  ALU operation
- branchcon  out  2  branch compare mode
- fault  out  1  sticky fault flag
- state  out  4  current FSM state, for debug

Function
REQ-004 SHALL implement a multicycle FSM with these states: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECUTE, ALUWB, JR, BRANCH, IEXEC, IWB, JUMP, FAULT.
REQ-005 Outputs are Moore (decoded from state) with three exceptions: irwrite, pcen and the FETCH PC update also depend on mem_ready or comparator_result, as stated below.
REQ-006 FETCH: mem_req=1, iord=0, alusrca=0, alusrcb=01, alucontrol=0010, pcsrc=00. When mem_ready=1: irwrite=1, pcen=1, next state DECODE. Otherwise FETCH holds.
REQ-007 DECODE: alusrca=0, alusrcb=11, alucontrol=0010. Next state by op:
- 100011 or 101011 -> MEMADR
- 000000 -> EXECUTE
- 000100, 000001, 000111 -> BRANCH
- 001000, 001100, 001101 -> IEXEC
- 000010 -> JUMP
- anything else -> FAULT
REQ-008 MEMADR: alusrca=1, alusrcb=10, alucontrol=0010; next state MEMRD for lw, MEMWR for sw.
REQ-009 MEMRD: mem_req=1, iord=1; advances to MEMWB on mem_ready.
REQ-010 MEMWB: regwrite=1, regdst=0, memtoreg=1; next state FETCH.
REQ-011 MEMWR: mem_req=1, iord=1, memwrite=1; advances to FETCH on mem_ready.
REQ-012 EXECUTE: alusrca=1, alusrcb=00, alucontrol decoded from funct:
- add 0010, sub 1010, and 0000, or 0001, slt 1011, xor 0110, srl/srlv 0100
- funct 001000 -> JR
- unknown funct -> FAULT
- otherwise -> ALUWB
REQ-013 ALUWB: regwrite=1, regdst=1, memtoreg=0; next state FETCH.
REQ-014 JR: pcsrc=11, pcen=1, alucontrol=0101; next state FETCH.
REQ-015 BRANCH: branch=1, alusrca=1, alusrcb=00, pcsrc=01, pcen=comparator_result; next state FETCH. Per op:
- beq: alucontrol=1010, branchcon=01
- bltz: alucontrol=0101, branchcon=10
- bgtz: alucontrol=0101, branchcon=11
REQ-016 IEXEC: alusrca=1, alusrcb=10; alucontrol add/and/or per opcode; i_type=1 for andi/ori. IWB: regwrite=1, regdst=0; next state FETCH.
REQ-017 JUMP: pcsrc=10, pcen=1; next state FETCH.
REQ-018 Wait counter behaviour:
- clears on entry to FETCH, MEMRD and MEMWR
- increments each cycle mem_req=1 and mem_ready=0
- when WAIT_MAX≠0 and the count reaches WAIT_MAX, next state is FAULT
- mem_ready=1 in the same cycle as the limit wins
REQ-019 FAULT: fault=1; all write enables (memwrite, regwrite, irwrite, pcen) and mem_req=0; FAULT is left only by reset.
REQ-020 Every output not specified for a state SHALL be 0. alucontrol SHALL never be X.

Reset
REQ-021 While reset=1, regardless of clk: state=FETCH, counter=0, fault=0, and all write enables, including irwrite, pcen and memwrite, deasserted.
REQ-022 After reset deasserts, FETCH begins on the next rising edge.

Structure
REQ-023 Package mc_pkg SHALL hold:
- the state enum
- opcode constants
- funct constants
- alucontrol constants
- branchcon constants
REQ-024 The funct/op-to-alucontrol decode SHALL be a combinational sub-module mc_aludec. The FSM and counter SHALL stay in mc_controller.

Verification
REQ-025 add (op=0, funct=100000) with mem_ready=1 -> FETCH→DECODE→EXECUTE→ALUWB in 4 cycles; alucontrol=0010 in EXECUTE; regwrite=1 and regdst=1 in ALUWB.
REQ-026 lw with mem_ready delayed 3 cycles in MEMRD -> MEMRD held 4 cycles; then MEMWB with memtoreg=1; total 8 cycles.
REQ-027 beq:
- comparator_result=1 -> BRANCH shows pcen=1, alucontrol=1010, branchcon=01
- comparator_result=0 -> pcen=0
REQ-028 WAIT_MAX=4, mem_ready held 0 in FETCH -> FAULT entered after 4 cycles; fault stays 1 until reset.
REQ-029 op=111111, or ENABLE_EXT=0 with op=000111 -> DECODE→FAULT; no write enable is ever asserted.
REQ-030 reset asserted mid-MEMWR -> memwrite drops asynchronously; state=FETCH before the next edge.

Source files
------------

// File: rtl/mc_pkg.sv
// Multicycle controller shared definitions.
// Holds the FSM state encoding, instruction opcode and function-field
// constants, ALU operation codes, branch-compare modes, and a helper that
// identifies the extension R-type functions.
package mc_pkg;

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_EXECUTE = 4'd6,
        S_ALUWB   = 4'd7,
        S_JR      = 4'd8,
        S_BRANCH  = 4'd9,
        S_IEXEC   = 4'd10,
        S_IWB     = 4'd11,
        S_JUMP    = 4'd12,
        S_FAULT   = 4'd13
    } state_t;

    // Opcodes
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_BLTZ  = 6'b000001;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BGTZ  = 6'b000111;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    // R-type function fields
    localparam logic [5:0] F_SRL  = 6'b000010;
    localparam logic [5:0] F_SRLV = 6'b000110;
    localparam logic [5:0] F_JR   = 6'b001000;
    localparam logic [5:0] F_ADD  = 6'b100000;
    localparam logic [5:0] F_SUB  = 6'b100010;
    localparam logic [5:0] F_AND  = 6'b100100;
    localparam logic [5:0] F_OR   = 6'b100101;
    localparam logic [5:0] F_XOR  = 6'b100110;
    localparam logic [5:0] F_SLT  = 6'b101010;

    // ALU operations
    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_OR   = 4'b0001;
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_SRL  = 4'b0100;
    localparam logic [3:0] ALU_PASS = 4'b0101;
    localparam logic [3:0] ALU_XOR  = 4'b0110;
    localparam logic [3:0] ALU_SUB  = 4'b1010;
    localparam logic [3:0] ALU_SLT  = 4'b1011;

    // Branch compare modes
    localparam logic [1:0] BC_NONE = 2'b00;
    localparam logic [1:0] BC_EQ   = 2'b01;
    localparam logic [1:0] BC_LTZ  = 2'b10;
    localparam logic [1:0] BC_GTZ  = 2'b11;

    function automatic logic is_ext_funct(input logic [5:0] f);
        return (f == F_XOR) || (f == F_SRL) || (f == F_SRLV);
    endfunction

endpackage

// File: rtl/mc_aludec.sv
// Combinational ALU decode for the multicycle controller.
// Ports:
//   op, funct  : instruction opcode and function field
//   r_alu      : ALU operation for R-type instructions
//   r_legal    : funct is a recognised R-type function (jr included)
//   b_alu      : ALU operation for the branch selected by op
//   b_con      : branch compare mode for the branch selected by op
//   i_alu      : ALU operation for immediate instructions
module mc_aludec import mc_pkg::*; #(
    parameter int ENABLE_EXT = 1
) (
    input  logic [5:0] op,
    input  logic [5:0] funct,
    output logic [3:0] r_alu,
    output logic       r_legal,
    output logic [3:0] b_alu,
    output logic [1:0] b_con,
    output logic [3:0] i_alu
);

    always_comb begin
        r_alu   = ALU_AND;
        r_legal = 1'b0;
        case (funct)
            F_ADD: begin r_alu = ALU_ADD; r_legal = 1'b1; end
            F_SUB: begin r_alu = ALU_SUB; r_legal = 1'b1; end
            F_AND: begin r_alu = ALU_AND; r_legal = 1'b1; end
            F_OR:  begin r_alu = ALU_OR;  r_legal = 1'b1; end
            F_SLT: begin r_alu = ALU_SLT; r_legal = 1'b1; end
            F_JR:  r_legal = 1'b1;
            default: begin
                // Extension functions are rejected entirely when disabled.
                if (ENABLE_EXT != 0 && is_ext_funct(funct)) begin
                    r_alu   = (funct == F_XOR) ? ALU_XOR : ALU_SRL;
                    r_legal = 1'b1;
                end
            end
        endcase
    end

    always_comb begin
        b_alu = ALU_AND;
        b_con = BC_NONE;
        case (op)
            OP_BEQ:  begin b_alu = ALU_SUB;  b_con = BC_EQ;  end
            OP_BLTZ: begin b_alu = ALU_PASS; b_con = BC_LTZ; end
            OP_BGTZ: begin b_alu = ALU_PASS; b_con = BC_GTZ; end
            default: ;
        endcase
    end

    always_comb begin
        case (op)
            OP_ANDI: i_alu = ALU_AND;
            OP_ORI:  i_alu = ALU_OR;
            default: i_alu = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/mc_controller.sv
// Multicycle processor controller: FSM sequencing fetch, decode, memory,
// ALU, branch and jump steps, with a memory-wait timeout that traps into a
// sticky FAULT state.
// Ports:
//   clk, reset           : clock, asynchronous active-high reset
//   op, funct            : instruction fields from the instruction register
//   comparator_result    : branch condition from the datapath
//   mem_ready            : memory access complete
//   mem_req..branchcon   : datapath control (muxes, enables, ALU op)
//   if_srl, jump_register: instruction-field decodes for the datapath
//   fault                : sticky fault flag
//   state                : current FSM state for debug
module mc_controller import mc_pkg::*; #(
    parameter int WAIT_MAX   = 15,
    parameter int ENABLE_EXT = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       comparator_result,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       iord,
    output logic       irwrite,
    output logic       memwrite,
    output logic       regwrite,
    output logic       regdst,
    output logic       memtoreg,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic [1:0] pcsrc,
    output logic       pcen,
    output logic       branch,
    output logic       i_type,
    output logic       if_srl,
    output logic       jump_register,
    output logic [3:0] alucontrol,
    output logic [1:0] branchcon,
    output logic       fault,
    output logic [3:0] state
);

    localparam int CNT_W = (WAIT_MAX > 1) ? $clog2(WAIT_MAX + 1) : 1;

    state_t           cur, nxt;
    logic [CNT_W-1:0] count;
    logic             mreq, irw, mwr, rwr, pce;
    logic             waiting, timeout, entering;
    logic [3:0]       r_alu, b_alu, i_alu;
    logic             r_legal;
    logic [1:0]       b_con;

    mc_aludec #(.ENABLE_EXT(ENABLE_EXT)) u_aludec (
        .op      (op),
        .funct   (funct),
        .r_alu   (r_alu),
        .r_legal (r_legal),
        .b_alu   (b_alu),
        .b_con   (b_con),
        .i_alu   (i_alu)
    );

    assign waiting = mreq & ~mem_ready;
    // A ready response in the limit cycle is a success, hence gating on waiting.
    assign timeout = (WAIT_MAX != 0) && waiting && ((int'(count) + 1) >= WAIT_MAX);
    assign entering = (nxt != cur) &&
                      (nxt == S_FETCH || nxt == S_MEMRD || nxt == S_MEMWR);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cur   <= S_FETCH;
            count <= '0;
        end else begin
            cur <= nxt;
            if (entering)
                count <= '0;
            else if (waiting)
                count <= count + 1'b1;
        end
    end

    always_comb begin
        nxt        = cur;
        mreq       = 1'b0;
        iord       = 1'b0;
        irw        = 1'b0;
        mwr        = 1'b0;
        rwr        = 1'b0;
        pce        = 1'b0;
        regdst     = 1'b0;
        memtoreg   = 1'b0;
        alusrca    = 1'b0;
        alusrcb    = 2'b00;
        pcsrc      = 2'b00;
        branch     = 1'b0;
        i_type     = 1'b0;
        alucontrol = ALU_AND;
        branchcon  = BC_NONE;
        case (cur)
            S_FETCH: begin
                mreq       = 1'b1;
                alusrcb    = 2'b01;
                alucontrol = ALU_ADD;
                if (mem_ready) begin
                    irw = 1'b1;
                    pce = 1'b1;
                    nxt = S_DECODE;
                end
            end
            S_DECODE: begin
                alusrcb    = 2'b11;
                alucontrol = ALU_ADD;
                case (op)
                    OP_LW, OP_SW:             nxt = S_MEMADR;
                    OP_RTYPE:                 nxt = S_EXECUTE;
                    OP_BEQ:                   nxt = S_BRANCH;
                    OP_BLTZ, OP_BGTZ:         nxt = (ENABLE_EXT != 0) ? S_BRANCH : S_FAULT;
                    OP_ADDI, OP_ANDI, OP_ORI: nxt = S_IEXEC;
                    OP_J:                     nxt = S_JUMP;
                    default:                  nxt = S_FAULT;
                endcase
            end
            S_MEMADR: begin
                alusrca    = 1'b1;
                alusrcb    = 2'b10;
                alucontrol = ALU_ADD;
                nxt        = (op == OP_SW) ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
                mreq = 1'b1;
                iord = 1'b1;
                if (mem_ready) nxt = S_MEMWB;
            end
            S_MEMWB: begin
                rwr      = 1'b1;
                memtoreg = 1'b1;
                nxt      = S_FETCH;
            end
            S_MEMWR: begin
                mreq = 1'b1;
                iord = 1'b1;
                mwr  = 1'b1;
                if (mem_ready) nxt = S_FETCH;
            end
            S_EXECUTE: begin
                alusrca    = 1'b1;
                alucontrol = r_alu;
                if (!r_legal)            nxt = S_FAULT;
                else if (funct == F_JR)  nxt = S_JR;
                else                     nxt = S_ALUWB;
            end
            S_ALUWB: begin
                rwr    = 1'b1;
                regdst = 1'b1;
                nxt    = S_FETCH;
            end
            S_JR: begin
                pcsrc      = 2'b11;
                pce        = 1'b1;
                alucontrol = ALU_PASS;
                nxt        = S_FETCH;
            end
            S_BRANCH: begin
                branch     = 1'b1;
                alusrca    = 1'b1;
                pcsrc      = 2'b01;
                pce        = comparator_result;
                alucontrol = b_alu;
                branchcon  = b_con;
                nxt        = S_FETCH;
            end
            S_IEXEC: begin
                alusrca    = 1'b1;
                alusrcb    = 2'b10;
                alucontrol = i_alu;
                i_type     = (op == OP_ANDI) || (op == OP_ORI);
                nxt        = S_IWB;
            end
            S_IWB: begin
                rwr = 1'b1;
                nxt = S_FETCH;
            end
            S_JUMP: begin
                pcsrc = 2'b10;
                pce   = 1'b1;
                nxt   = S_FETCH;
            end
            S_FAULT: nxt = S_FAULT;
            default: nxt = S_FAULT;
        endcase
        if (timeout) nxt = S_FAULT;
    end

    // Enables are forced low combinationally so they drop the instant reset rises.
    assign mem_req       = mreq & ~reset;
    assign irwrite       = irw  & ~reset;
    assign memwrite      = mwr  & ~reset;
    assign regwrite      = rwr  & ~reset;
    assign pcen          = pce  & ~reset;
    assign fault         = (cur == S_FAULT);
    assign state         = cur;
    assign if_srl        = (op == OP_RTYPE) && (funct == F_SRL);
    assign jump_register = (funct == F_JR);

endmodule
